// File: rtl/joint_pkg.sv
// Shared definitions for the joint frequency ramp: command width and ramp FSM states.
package joint_pkg;

  localparam int FREQ_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } ramp_state_e;

endpackage

// File: rtl/ramp_tick_gen.sv
// Ramp tick divider: counts 0..TICK_DIV-1 and pulses tick for one cycle on the last count.
module ramp_tick_gen #(
  parameter int TICK_DIV = 48
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A cleared divider never fires, so a disabled joint sees no stray tick.
  assign tick = (cnt_q == LAST) && !clr;

endmodule

// File: rtl/joint_freq_ramp.sv
// Slew-limited joint frequency command with host-update watchdog and ramp/hold FSM.
// targetValid is a one-cycle strobe with no back-pressure; targetFreq is sampled only on it.
module joint_freq_ramp
  import joint_pkg::*;
#(
  parameter int TICK_DIV   = 48,
  parameter int ACC_STEP   = 100,
  parameter int MAX_FREQ   = 2000000,
  parameter int WDT_CYCLES = 4800000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     jointEnable,
  input  logic signed [FREQ_W-1:0] targetFreq,
  input  logic                     targetValid,
  output logic signed [FREQ_W-1:0] jointFreqCmd,
  output logic                     atTarget,
  output logic                     wdtTimeout,
  output logic [1:0]               state_o
);

  localparam int WW = $clog2(WDT_CYCLES + 1);
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES);
  localparam logic signed [FREQ_W-1:0] MAX_S   = FREQ_W'(MAX_FREQ);
  localparam logic signed [FREQ_W-1:0] MIN_S   = -MAX_S;
  localparam logic signed [FREQ_W-1:0] STEP32  = FREQ_W'(ACC_STEP);
  localparam logic signed [FREQ_W:0]   STEP33  = (FREQ_W + 1)'(ACC_STEP);
  localparam logic signed [FREQ_W:0]   NSTEP33 = -STEP33;

  ramp_state_e state_q, state_d;
  logic signed [FREQ_W-1:0] tgt_q, tgt_d, cmd_d, eff, tgt_sat;
  logic signed [FREQ_W:0]   diff;
  logic [WW-1:0]            wdt_cnt_q, wdt_cnt_d;
  logic                     wdt_d, at_target_d, tick;

  ramp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (!jointEnable),
    .tick (tick)
  );

  always_comb begin
    tgt_sat = targetFreq;
    if (targetFreq > MAX_S) tgt_sat = MAX_S;
    else if (targetFreq < MIN_S) tgt_sat = MIN_S;
    tgt_d = targetValid ? tgt_sat : tgt_q;
  end

  // The flag is set by the same edge at which the count reaches its limit.
  always_comb begin
    wdt_cnt_d = wdt_cnt_q;
    wdt_d     = wdtTimeout;
    if (targetValid) begin
      wdt_cnt_d = '0;
      wdt_d     = 1'b0;
    end else if (wdt_cnt_q != WDT_LAST) begin
      wdt_cnt_d = wdt_cnt_q + 1'b1;
      if (wdt_cnt_d == WDT_LAST) wdt_d = 1'b1;
    end
  end

  // The 33-bit difference keeps every step in range; a step never overshoots eff.
  always_comb begin
    eff   = (wdtTimeout || !jointEnable) ? '0 : tgt_q;
    diff  = {eff[FREQ_W-1], eff} - {jointFreqCmd[FREQ_W-1], jointFreqCmd};
    cmd_d = jointFreqCmd;
    if (!jointEnable) begin
      cmd_d = '0;
    end else if (tick) begin
      if (diff > STEP33) cmd_d = jointFreqCmd + STEP32;
      else if (diff < NSTEP33) cmd_d = jointFreqCmd - STEP32;
      else cmd_d = eff;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!jointEnable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = RAMP;
        RAMP:    if (cmd_d == eff) state_d = HOLD;
        HOLD:    if (cmd_d != eff) state_d = RAMP;
        default: state_d = IDLE;
      endcase
    end
    at_target_d = (state_d != RAMP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tgt_q        <= '0;
      jointFreqCmd <= '0;
      wdt_cnt_q    <= '0;
      wdtTimeout   <= 1'b0;
      atTarget     <= 1'b1;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      jointFreqCmd <= cmd_d;
      wdt_cnt_q    <= wdt_cnt_d;
      wdtTimeout   <= wdt_d;
      atTarget     <= at_target_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_joint_freq_ramp.sv
// Randomized bench for joint_freq_ramp against an arithmetic cycle model of the ramp rules.
module tb_joint_freq_ramp;
  import joint_pkg::*;

  localparam int TICK_DIV   = 4;
  localparam int ACC_STEP   = 1000;
  localparam int MAX_FREQ   = 100000;
  localparam int WDT_CYCLES = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic jointEnable = 1'b0;
  logic targetValid = 1'b0;
  logic signed [31:0] targetFreq = '0;
  logic signed [31:0] jointFreqCmd;
  logic atTarget, wdtTimeout;
  logic [1:0] state_o;

  joint_freq_ramp #(
    .TICK_DIV(TICK_DIV), .ACC_STEP(ACC_STEP), .MAX_FREQ(MAX_FREQ), .WDT_CYCLES(WDT_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .jointEnable(jointEnable), .targetFreq(targetFreq),
    .targetValid(targetValid), .jointFreqCmd(jointFreqCmd), .atTarget(atTarget),
    .wdtTimeout(wdtTimeout), .state_o(state_o)
  );

  // clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  longint m_cmd = 0, m_tgt = 0;
  int m_phase = 0, m_wdt_cnt = 0;
  bit m_wdt = 0, m_at = 1, m_en_prev = 0;

  task automatic check(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > MAX_FREQ) return MAX_FREQ;
    if (v < -MAX_FREQ) return -MAX_FREQ;
    return v;
  endfunction

  task automatic model_edge(input bit rst, input bit en, input bit tv, input longint tf);
    longint eff, d;
    if (rst) begin
      m_cmd = 0; m_tgt = 0; m_phase = 0; m_wdt_cnt = 0; m_wdt = 0; m_at = 1; m_en_prev = 0;
    end else begin
      eff = (m_wdt || !en) ? 0 : m_tgt;
      if (!en) begin
        m_cmd = 0;
      end else if (m_phase == TICK_DIV - 1) begin
        d = eff - m_cmd;
        if (d > ACC_STEP) m_cmd = m_cmd + ACC_STEP;
        else if (d < -ACC_STEP) m_cmd = m_cmd - ACC_STEP;
        else m_cmd = eff;
      end
      m_phase = en ? (m_phase + 1) % TICK_DIV : 0;
      m_at = !en ? 1'b1 : (!m_en_prev ? 1'b0 : (m_cmd == eff));
      m_en_prev = en;
      if (tv) begin
        m_tgt = sat(tf); m_wdt_cnt = 0; m_wdt = 0;
      end else if (m_wdt_cnt < WDT_CYCLES) begin
        m_wdt_cnt++;
        if (m_wdt_cnt == WDT_CYCLES) m_wdt = 1;
      end
    end
    exp_q.push_back(m_cmd[31:0]);
  endtask

  // driver: apply inputs, let one edge pass, then compare against the model
  task automatic drive(input bit rst, input bit en, input bit tv, input logic signed [31:0] tf);
    logic [31:0] e;
    logic [1:0] exp_state;
    rst_n = !rst; jointEnable = en; targetValid = tv; targetFreq = tf;
    @(posedge clk);
    model_edge(rst, en, tv, longint'(tf));
    #1;
    e = exp_q.pop_front();
    exp_state = !m_en_prev ? IDLE : (m_at ? HOLD : RAMP);
    check("cmd", jointFreqCmd, $signed(e));
    check("at_target", atTarget, m_at);
    check("wdt_timeout", wdtTimeout, m_wdt);
    check("state", state_o, exp_state);
  endtask

  task automatic idle_cycles(input int n, input bit en);
    for (int i = 0; i < n; i++) drive(0, en, 0, '0);
  endtask

  initial begin
    logic signed [31:0] tf;
    bit en, tv, rst;
    int tv_div;

    for (int i = 0; i < 3; i++) drive(1, 0, 0, '0);
    check("reset_cmd", jointFreqCmd, 0);
    check("reset_at", atTarget, 1);
    check("reset_wdt", wdtTimeout, 0);

    drive(0, 1, 1, 32'sd5000);
    idle_cycles(3, 1);
    check("first_step", jointFreqCmd, 1000);
    idle_cycles(20, 1);
    check("ramp_up_end", jointFreqCmd, 5000);
    check("ramp_up_at", atTarget, 1);

    drive(0, 1, 1, -32'sd2500);
    idle_cycles(39, 1);
    check("ramp_down_end", jointFreqCmd, -2500);
    check("ramp_down_at", atTarget, 1);

    drive(0, 1, 1, 32'sh8000_0000);
    idle_cycles(400, 1);
    check("sat_low", jointFreqCmd, -100000);
    drive(0, 1, 1, 32'sh7FFF_FFFF);
    idle_cycles(820, 1);
    check("sat_high", jointFreqCmd, 100000);

    drive(0, 1, 1, 32'sd3000);
    idle_cycles(1030, 1);
    check("wdt_set", wdtTimeout, 1);
    check("wdt_ramp_zero", jointFreqCmd, 0);
    drive(0, 1, 1, 32'sd4000);
    check("wdt_clear", wdtTimeout, 0);
    idle_cycles(30, 1);
    check("pre_disable", jointFreqCmd, 4000);
    drive(0, 0, 0, '0);
    check("disable_cmd", jointFreqCmd, 0);
    check("disable_at", atTarget, 1);
    idle_cycles(4, 1);
    check("reenable_step", jointFreqCmd, 1000);
    idle_cycles(8, 1);
    check("pre_reset", jointFreqCmd, 3000);
    drive(1, 1, 0, '0);
    check("midramp_reset_cmd", jointFreqCmd, 0);
    check("midramp_reset_at", atTarget, 1);

    en = 1;
    tv_div = 20;
    for (int i = 0; i < 20000; i++) begin
      if (i % 2000 == 0) tv_div = ($urandom_range(0, 2) == 0) ? 1500 : 20;
      if ($urandom_range(0, 199) == 0) en = !en;
      rst = ($urandom_range(0, 2999) == 0);
      tv = ($urandom_range(0, tv_div - 1) == 0);
      case ($urandom_range(0, 3))
        0: tf = $urandom;
        1: tf = ($urandom_range(0, 1) == 0) ? 32'sh7FFF_FFFF : 32'sh8000_0000;
        default: tf = 32'(int'($urandom_range(0, 20000)) - 10000);
      endcase
      drive(rst, en, tv, tf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/joint_freq_ramp.md
JOINT_FREQ_RAMP -- requirements
Module: joint_freq_ramp

Interface
REQ-001 Parameter TICK_DIV, default 48, clk cycles per ramp tick (>=1).
REQ-002 Parameter ACC_STEP, default 100, max |jointFreqCmd| change per tick (>=1).
REQ-003 Parameter MAX_FREQ, default 2000000, saturation bound for |target|.
REQ-004 Parameter WDT_CYCLES, default 4800000, host-update watchdog timeout in clk cycles.
REQ-005 clk  in  1  system clock; sole clock domain.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 jointEnable  in  1  joint enable; low forces output to zero.
REQ-008 targetFreq  in  32 signed  host target step frequency.
REQ-009 targetValid  in  1  one-cycle strobe; targetFreq is valid on it.
REQ-010 jointFreqCmd  out  32 signed  slew-limited frequency command to the downstream joint_pwmdir stage.
REQ-011 atTarget  out  1  high when jointFreqCmd equals effective target.
REQ-012 wdtTimeout  out  1  sticky watchdog-expired flag.

Function
REQ-013 On targetValid, tgt_q SHALL latch targetFreq saturated to [-MAX_FREQ, +MAX_FREQ] at the next clk edge.
REQ-014 Effective target SHALL be 0 when wdtTimeout=1 or jointEnable=0, otherwise tgt_q.
REQ-015 Tick counter SHALL run 0..TICK_DIV-1 and wrap; tick asserts for one cycle when count==TICK_DIV-1.
REQ-016 On tick, with d = effective target - jointFreqCmd computed at 33 bits signed: |d|<=ACC_STEP -> jointFreqCmd := target; d>0 -> jointFreqCmd += ACC_STEP; d<0 -> jointFreqCmd -= ACC_STEP; no overflow for any 32-bit input.
REQ-017 Tick SHALL use tgt_q as registered before the edge; a targetValid coincident with tick affects the following tick.
REQ-018 jointEnable=0 SHALL force jointFreqCmd to 0 at the next edge (no ramp), hold it there, and clear tick counter; target latching continues.
REQ-019 Zero crossings SHALL ramp through 0 with no special handling (direction reversal is downstream's concern).
REQ-020 Watchdog counter SHALL clear on targetValid, else increment, saturating at WDT_CYCLES; on reaching WDT_CYCLES wdtTimeout:=1.
REQ-021 wdtTimeout SHALL clear only on targetValid or reset; targetValid coincident with expiry wins (flag stays 0).
REQ-022 FSM states: IDLE (jointEnable=0), RAMP (output != effective target), HOLD (output == effective target); IDLE->RAMP on enable; RAMP->HOLD when equal; HOLD->RAMP when target changes; any->IDLE on enable low.
REQ-023 atTarget SHALL be registered, high exactly in HOLD and IDLE.
REQ-024 All outputs SHALL be registered; latency from a tick to changed jointFreqCmd is one cycle.

Reset
REQ-025 rst_n=0 at an edge SHALL set jointFreqCmd=0, tgt_q=0, tick count=0, watchdog count=0, wdtTimeout=0, atTarget=1, state=IDLE.
REQ-026 Reset mid-ramp SHALL take effect at the next edge with no residual step.

Structure
REQ-027 Shared package joint_pkg SHALL hold FREQ_W=32 and the state enum (IDLE, RAMP, HOLD).
REQ-028 Tick divider SHALL be sub-module ramp_tick_gen (params TICK_DIV; ports clk, rst_n, clr, tick).

Verification (TICK_DIV=4, ACC_STEP=1000, MAX_FREQ=100000, WDT_CYCLES=1000)
REQ-029 Enable, target 5000 -> output 1000,2000,...,5000 one per 4 cycles, then atTarget=1.
REQ-030 Output 5000, target -2500 -> 4000,...,-2000,-2500 (final partial step), atTarget=1.
REQ-031 Target 0x7FFFFFFF -> tgt_q=100000; from -100000 ramps up with no wrap.
REQ-032 Output 3000, no targetValid for 1000 cycles -> wdtTimeout=1, ramps 2000,1000,0; next targetValid clears flag.
REQ-033 Output 4000, drop jointEnable -> next cycle output 0, atTarget=1; re-enable -> ramps from 0.
REQ-034 Reset asserted mid-ramp at 3000 -> next edge all outputs at reset values.
